// File: rtl/jk_updown_counter_n.sv
// jk_updown_counter_n
//   Parametrised synchronous up/down counter built from per-bit JK cells.
//   Each bit toggles (J = K = t[i]) from a ripple-style carry/borrow term;
//   a set/reset override on J/K handles parallel load and the modulus
//   boundary, so any MAX_COUNT below 2**WIDTH-1 still wraps cleanly.
//
//   Build option: define JKCNT_SATURATE_EN to saturate at the boundaries
//   instead of wrapping (tc unchanged, wrap flags each held boundary cycle).
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   MAX_COUNT  highest count value; modulus is MAX_COUNT+1
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   en        in   count enable
//   up_down   in   direction, 1 = up, 0 = down
//   load      in   synchronous parallel load strobe (priority over en)
//   load_val  in   value to load, clamped to MAX_COUNT
//   q         out  registered count
//   tc        out  terminal count (combinational, low during load)
//   wrap      out  registered one-cycle pulse after a boundary event
module jk_updown_counter_n #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] load_sat;
    logic [WIDTH-1:0] bnd_tgt;
    logic             up_and, dn_and;
    logic             at_top, above_top, at_bot;
    logic             bnd_ovr;

    // Toggle terms: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        t      = '0;
        up_and = 1'b1;
        dn_and = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]   = en & (up_down ? up_and : dn_and);
            up_and = up_and & cnt_q[i];
            dn_and = dn_and & ~cnt_q[i];
        end
    end

    assign at_top    = (cnt_q == MAX_V);
    assign above_top = (cnt_q > MAX_V);
    assign at_bot    = (cnt_q == '0);

    assign tc = en & ~load & ((up_down & at_top) | (~up_down & at_bot));

    // Out-of-range states (only reachable through a reset-release glitch)
    // are steered back into range when counting up.
    assign bnd_ovr = en & ((up_down & (at_top | above_top)) | (~up_down & at_bot));

`ifdef JKCNT_SATURATE_EN
    assign bnd_tgt = up_down ? MAX_V : '0;
`else
    assign bnd_tgt = up_down ? '0 : MAX_V;
`endif

    assign load_sat = (load_val > MAX_V) ? MAX_V : load_val;

    // J/K selection: load and boundary use set/reset, otherwise toggle.
    always_comb begin
        j = t;
        k = t;
        if (load) begin
            j = load_sat;
            k = ~load_sat;
        end else if (bnd_ovr) begin
            j = bnd_tgt;
            k = ~bnd_tgt;
        end
    end

    // JK characteristic equation, bitwise: Q+ = J & ~Q | ~K & Q.
    assign cnt_d  = (j & ~cnt_q) | (~k & cnt_q);
    assign wrap_d = tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;

endmodule
